// File: rtl/bus_pkg.sv
// Shared types and constants for the bus decoder: FSM states, region tags,
// default wait states and a helper that maps a region to its select index.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    REG0     = 3'd0,
    REG1     = 3'd1,
    REG2     = 3'd2,
    REG3     = 3'd3,
    REG_NONE = 3'd4
  } region_t;

  localparam int NUM_REGIONS = 4;

  // Upper address nibble that selects each region.
  localparam logic [3:0] TAG_REG0 = 4'h0;
  localparam logic [3:0] TAG_REG1 = 4'h1;
  localparam logic [3:0] TAG_REG2 = 4'h2;
  localparam logic [3:0] TAG_REG3 = 4'h3;

  localparam int DEF_WAIT0 = 0;
  localparam int DEF_WAIT1 = 1;
  localparam int DEF_WAIT2 = 2;
  localparam int DEF_WAIT3 = 4;

  // Region to rdsel/cs index; REG_NONE never reaches a select, so it maps to 0.
  function automatic logic [1:0] region_idx(input region_t r);
    case (r)
      REG1:    region_idx = 2'd1;
      REG2:    region_idx = 2'd2;
      REG3:    region_idx = 2'd3;
      default: region_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Combinational address-tag decoder: upper address nibble -> region and mapped flag.
module bus_region_decode
  import bus_pkg::*;
(
  input  logic [3:0] tag,
  output region_t    region,
  output logic       mapped
);

  // Compare the tag against each region's constant; anything else is unmapped.
  always_comb begin
    case (tag)
      TAG_REG0: region = REG0;
      TAG_REG1: region = REG1;
      TAG_REG2: region = REG2;
      TAG_REG3: region = REG3;
      default:  region = REG_NONE;
    endcase
    mapped = (region != REG_NONE);
  end

endmodule

// File: rtl/bus_decoder.sv
// Single-requester bus decoder: accepts a transfer in IDLE, drives a one-hot
// peripheral select for one ACCESS cycle plus per-region wait states, then
// pulses ready for one cycle. Unmapped addresses complete at once with err.
module bus_decoder
  import bus_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int WAIT0 = DEF_WAIT0,
  parameter int WAIT1 = DEF_WAIT1,
  parameter int WAIT2 = DEF_WAIT2,
  parameter int WAIT3 = DEF_WAIT3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] readData,
  output logic [3:0]       cs,
  output logic [3:0]       wen,
  output logic [WIDTH-1:0] paddr,
  output logic [WIDTH-1:0] pwdata,
  output logic [1:0]       rdsel,
  output logic             ready,
  output logic             err,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [3:0] WAIT_TAB [NUM_REGIONS] = '{4'(WAIT0), 4'(WAIT1), 4'(WAIT2), 4'(WAIT3)};

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             we_reg;
  logic             mapped_reg;
  logic [1:0]       rdsel_reg;
  logic [WIDTH-1:0] paddr_reg;
  logic [WIDTH-1:0] pwdata_reg;

  region_t          dec_region;
  logic             dec_mapped;
  logic             accept;
  logic [3:0]       wait_sel;

  bus_region_decode u_decode (
    .tag    (addr[WIDTH-1 -: 4]),
    .region (dec_region),
    .mapped (dec_mapped)
  );

  assign accept   = (state_reg == ST_IDLE) && req;
  assign wait_sel = WAIT_TAB[rdsel_reg];

  // Next-state and wait-counter logic; only IDLE looks at req.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) state_next = dec_mapped ? ST_ACCESS : ST_DONE;
      end
      ST_ACCESS: begin
        cnt_next   = wait_sel;
        state_next = (wait_sel != 4'd0) ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        // Leave when the count goes 1 -> 0; a zero count exits defensively.
        if (cnt_reg <= 4'd1) state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counter and transfer latches; rdsel only moves on a mapped accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      mapped_reg <= 1'b0;
      rdsel_reg  <= 2'd0;
      paddr_reg  <= '0;
      pwdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        paddr_reg  <= addr;
        pwdata_reg <= wdata;
        we_reg     <= we;
        mapped_reg <= dec_mapped;
        if (dec_mapped) rdsel_reg <= region_idx(dec_region);
      end
    end
  end

  // One-hot select and write strobe per region, decoded from the latched index.
  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_sel
      assign cs[gi]  = ((state_reg == ST_ACCESS) || (state_reg == ST_WAIT)) &&
                       (rdsel_reg == 2'(gi));
      assign wen[gi] = (state_reg == ST_ACCESS) && we_reg && (rdsel_reg == 2'(gi));
    end
  endgenerate

  assign ready  = (state_reg == ST_DONE);
  assign err    = (state_reg == ST_DONE) && !mapped_reg;
  assign rdata  = ((state_reg == ST_DONE) && mapped_reg && !we_reg) ? readData : '0;
  assign paddr  = paddr_reg;
  assign pwdata = pwdata_reg;
  assign rdsel  = rdsel_reg;

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data and address width.
REQ-002 The module SHALL have parameters WAIT0, WAIT1, WAIT2, WAIT3, defaults 0, 1, 2, 4, giving the wait states per region (range 0..15).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have port req, input, 1 bit: the requester has a valid transfer.
REQ-006 The module SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-007 The module SHALL have port addr, input, WIDTH bits: byte address.
REQ-008 The module SHALL have port wdata, input, WIDTH bits: write data.
REQ-009 The module SHALL have port readData, input, WIDTH bits: peripheral read data, already selected by rdsel.
REQ-010 The module SHALL have port cs, output, 4 bits: one-hot peripheral select.
REQ-011 The module SHALL have port wen, output, 4 bits: one-hot peripheral write strobe.
REQ-012 The module SHALL have port paddr, output, WIDTH bits: latched address to peripherals.
REQ-013 The module SHALL have port pwdata, output, WIDTH bits: latched write data.
REQ-014 The module SHALL have port rdsel, output, 2 bits: read-select index of the active region.
REQ-015 The module SHALL have port ready, output, 1 bit: one-cycle transfer-complete pulse.
REQ-016 The module SHALL have port err, output, 1 bit: unmapped-access flag, valid with ready.
REQ-017 The module SHALL have port rdata, output, WIDTH bits: read response data, valid with ready.

Function
REQ-018 Address decode SHALL use addr[WIDTH-1:WIDTH-4]: 0x0 -> region 0, 0x1 -> region 1, 0x2 -> region 2, 0x3 -> region 3, any other value -> unmapped.
REQ-019 The FSM SHALL have the states IDLE, ACCESS, WAIT and DONE, and only IDLE SHALL sample req.
REQ-020 In IDLE with req=1, the block SHALL latch addr, wdata, we and region; the next state SHALL be ACCESS if mapped and DONE with err=1 if unmapped.
REQ-021 In ACCESS (exactly one cycle), cs[k]=1 and wen[k]=we_latched SHALL be driven; the wait counter SHALL be loaded with WAITk; the next state SHALL be WAIT if WAITk>0, else DONE.
REQ-022 In WAIT, cs[k] SHALL stay 1 and wen SHALL be 0; the counter SHALL decrement each cycle; on the transition 1->0 the next state SHALL be DONE.
REQ-023 In DONE (exactly one cycle), ready SHALL be 1; rdata SHALL equal readData for a mapped read and 0 otherwise; cs SHALL be 0; the next state SHALL be IDLE.
REQ-024 rdsel SHALL equal the latched region from ACCESS through DONE and SHALL hold its last value in IDLE.
REQ-025 paddr and pwdata SHALL hold the latched values from ACCESS until the next acceptance.
REQ-026 Latency from the acceptance edge to ready SHALL be 2+WAITk cycles mapped and 1 cycle unmapped.
REQ-027 With req held high, the next transfer SHALL be accepted in the IDLE cycle following DONE; there are no back-to-back acceptances without IDLE.
REQ-028 Changes on req/addr/we/wdata outside IDLE SHALL be ignored.
REQ-029 wen SHALL assert for at most one cycle per write; it SHALL never assert for reads or unmapped accesses.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE, cs=0, wen=0, ready=0, err=0, rdata=0, rdsel=0, paddr=0, pwdata=0, counter=0.
REQ-031 Reset mid-transfer SHALL drop the transfer with no ready pulse and no wen pulse afterwards.

Structure
REQ-032 Package bus_pkg SHALL hold the state enum, the region enum (REG0..REG3, REG_NONE), the 4-bit region tag constants and the default wait constants.
REQ-033 Sub-module bus_region_decode (combinational addr -> region, mapped flag) SHALL be instantiated once; the FSM and counter SHALL live in bus_decoder.

Verification
REQ-034 The bench SHALL cover: write addr=0x1000_0010, wdata=0xDEADBEEF -> wen=4'b0010 for 1 cycle at ACCESS, pwdata=0xDEADBEEF, ready 3 cycles after acceptance, err=0.
REQ-035 The bench SHALL cover: read addr=0x3000_0004, readData=0x0000_00A5 -> cs=4'b1000 for 5 cycles, rdsel=2'b11, ready at +6, rdata=0xA5, wen=0 throughout.
REQ-036 The bench SHALL cover: read addr=0x7000_0000 -> ready at +1, err=1, rdata=0, cs=0 and wen=0 throughout.
REQ-037 The bench SHALL cover: req held high for reads to 0x0000_0000 then 0x2000_0000 -> ready at +2, IDLE, second accepted, ready at +4 from its acceptance, rdsel 0 then 2.
REQ-038 The bench SHALL cover: write to 0x3000_0000, rst_n=0 during WAIT -> all outputs 0 next cycle, no ready or wen pulse afterwards.
REQ-039 The bench SHALL cover: addr changed to 0x2000_0000 during WAIT of a region-1 read -> cs stays 4'b0010, rdsel stays 1.
